// File: rtl/cpu_pkg.sv
// Shared ISA and sequencer definitions: opcodes, FSM encoding, flag bit positions.
// No logic or latency of its own.
// No flow control involved.
package cpu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JN  = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_JV  = 4'hD;
    localparam logic [3:0] OP_NOP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit positions inside the {Z,N,C,V} flag nibble
    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_IMM    = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/reg_file_4x8.sv
// Four 8-bit registers: two combinational operand reads, one debug read, one synchronous write.
// Reads are zero-latency; a write is visible the cycle after it is presented.
// No backpressure; a write is always accepted.
module reg_file_4x8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ra_sel,
    input  logic [1:0] rb_sel,
    input  logic [1:0] dbg_sel,
    output logic [7:0] ra_dat,
    output logic [7:0] rb_dat,
    output logic [7:0] dbg_dat,
    input  logic       wr_vld,
    input  logic [1:0] wr_sel,
    input  logic [7:0] wr_dat
);

    logic [3:0][7:0] regs_q;
    logic [3:0][7:0] regs_d;

    always_comb begin
        regs_d = regs_q;
        if (wr_vld) begin
            regs_d[wr_sel] = wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_dat  = regs_q[ra_sel];
    assign rb_dat  = regs_q[rb_sel];
    assign dbg_dat = regs_q[dbg_sel];

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer feeding an external 8-bit ALU from a 4x8 register file.
// ALU ops, LDI, JMP and Jcc take 3 cycles, NOP 2; HLT parks until reset.
// No backpressure: program memory and ALU are both combinational and always ready.
module control_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] pc,
    input  logic [7:0] mem_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic [3:0] flags,
    output logic       retire,
    output logic       halted,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_reg
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] flags_q, flags_d;

    logic [3:0] op;
    logic       branch_taken;
    logic       rf_wr_vld;
    logic [7:0] rf_wr_dat;
    logic       retire_raw;

    assign op = ir_q[7:4];

    reg_file_4x8 u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .ra_sel  (ir_q[3:2]),
        .rb_sel  (ir_q[1:0]),
        .dbg_sel (dbg_sel),
        .ra_dat  (alu_a),
        .rb_dat  (alu_b),
        .dbg_dat (dbg_reg),
        .wr_vld  (rf_wr_vld),
        .wr_sel  (ir_q[3:2]),
        .wr_dat  (rf_wr_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            flags_q <= 4'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_alu_op(op)) begin
                    state_d = ST_EXEC;
                end else if (op == OP_NOP) begin
                    state_d = ST_FETCH;
                end else if (op == OP_HLT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_IMM;
                end
            end
            ST_EXEC:   state_d = ST_FETCH;
            ST_IMM:    state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Conditional jumps test the flags as they stood before the jump
    always_comb begin
        branch_taken = 1'b0;
        case (op)
            OP_JMP:  branch_taken = 1'b1;
            OP_JZ:   branch_taken = flags_q[FZ];
            OP_JN:   branch_taken = flags_q[FN];
            OP_JC:   branch_taken = flags_q[FC];
            OP_JV:   branch_taken = flags_q[FV];
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        flags_d    = flags_q;
        rf_wr_vld  = 1'b0;
        rf_wr_dat  = alu_result;
        retire_raw = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d = mem_data;
                pc_d = pc_q + 8'd1;
            end
            ST_DECODE: begin
                retire_raw = (op == OP_NOP);
            end
            ST_EXEC: begin
                rf_wr_vld  = 1'b1;
                rf_wr_dat  = alu_result;
                flags_d    = alu_flags;
                retire_raw = 1'b1;
            end
            ST_IMM: begin
                retire_raw = 1'b1;
                if (op == OP_LDI) begin
                    rf_wr_vld = 1'b1;
                    rf_wr_dat = mem_data;
                    pc_d      = pc_q + 8'd1;
                end else if (branch_taken) begin
                    pc_d = mem_data;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
            end
            default: begin
            end
        endcase
    end

    assign pc      = pc_q;
    assign alu_sel = ir_q[6:4];
    assign flags   = flags_q;
    assign retire  = retire_raw & ~rst;
    assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    localparam logic [7:0] RESET_PC = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc;
    logic [7:0] mem_data;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic [3:0] flags;
    logic       retire, halted;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_reg;

    logic [7:0] mem [256];

    typedef struct {
        int              cyc;
        logic [7:0]      pc;
        logic [3:0]      flags;
        logic [3:0][7:0] regs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    control_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .pc(pc), .mem_data(mem_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_flags(alu_flags), .flags(flags),
        .retire(retire), .halted(halted), .dbg_sel(dbg_sel), .dbg_reg(dbg_reg)
    );

    always #5 clk = ~clk;

    assign mem_data = mem[pc];

    // Reference 8-bit ALU: returns {Z,N,C,V, result}
    function automatic logic [11:0] alu_f(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        logic [7:0] r;
        logic       c, v;
        t = 9'd0; c = 1'b0; v = 1'b0;
        case (sel)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin t = {1'b0, a} - {1'b0, b}; r = t[7:0]; c = t[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
            default: begin r = {1'b0, a[7:1]}; c = a[0]; end
        endcase
        return {(r == 8'h00), r[7], c, v, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_f(alu_sel, alu_a, alu_b);

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each retire pops the next expected instruction outcome
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && retire) begin
                if (q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("retire_cycle", cyc, e.cyc);
                    @(negedge clk);
                    chk("pc_after_retire", pc, e.pc);
                    chk("flags_after_retire", flags, e.flags);
                    chk("reg_after_retire", dbg_reg, e.regs[dbg_sel]);
                end
            end
        end
    end

    // ISA-level model: runs the program in mem from RESET_PC, queueing one outcome per instruction
    task automatic build_model(input int maxi, output int cum, output bit halt_m, output logic [7:0] hpc);
        logic [3:0][7:0] r;
        logic [3:0]      f;
        logic [7:0]      p, b;
        logic [11:0]     a;
        int              lat;
        exp_t            e;
        r = '0; f = 4'h0; p = RESET_PC; cum = 0; halt_m = 1'b0; hpc = 8'h00;
        for (int i = 0; i < maxi; i++) begin
            b = mem[p];
            p = p + 8'd1;
            lat = 3;
            if (b[7:4] == 4'hF) begin
                halt_m = 1'b1; hpc = p;
                break;
            end else if (b[7] == 1'b0) begin
                a = alu_f(b[6:4], r[b[3:2]], r[b[1:0]]);
                r[b[3:2]] = a[7:0];
                f = a[11:8];
            end else if (b[7:4] == 4'h8) begin
                r[b[3:2]] = mem[p];
                p = p + 8'd1;
            end else if (b[7:4] == 4'hE) begin
                lat = 2;
            end else begin
                if (b[7:4] == 4'h9 || f[3 - int'(b[7:4] - 4'hA)]) p = mem[p];
                else p = p + 8'd1;
            end
            cum += lat;
            e.cyc = cum - 1; e.pc = p; e.flags = f; e.regs = r;
            q.push_back(e);
        end
    endtask

    task automatic run_program(input int maxi);
        int         cum, n;
        bit         halt_m;
        logic [7:0] hpc;
        mon_en = 1'b0;
        q.delete();
        build_model(maxi, cum, halt_m, hpc);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        mon_en = 1'b1;
        n = 0;
        while (q.size() != 0 && n < cum + 20) begin
            @(posedge clk); #2 dbg_sel = 2'($urandom_range(0, 3));
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        if (halt_m) begin
            n = 0;
            while (cyc < cum + 2 && n < 60) begin
                @(negedge clk); n++;
            end
            repeat (5) begin
                @(negedge clk);
                chk("halted", halted, 1);
                chk("halt_pc", pc, hpc);
            end
        end
        mon_en = 1'b0;
    endtask

    task automatic chk_reg(input int idx, input logic [7:0] exp);
        dbg_sel = 2'(idx);
        #1 chk($sformatf("R%0d", idx), dbg_reg, exp);
    endtask

    task automatic reset_check();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_pc", pc, RESET_PC);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire, 0);
        chk("rst_flags", flags, 0);
        for (int i = 0; i < 4; i++) chk_reg(i, 8'h00);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        dbg_sel = 2'd0;
        clear_mem();
        reset_check();

        // LDI R0,#05; LDI R1,#03; ADD R0,R1; HLT
        clear_mem();
        {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'h80, 8'h05, 8'h84, 8'h03, 8'h01};
        run_program(50);
        chk_reg(0, 8'h08);
        chk("t1_flags", flags, 4'b0000);

        // LDI R2,#05; SUB R2,R2; JZ #20; HLT at 0x20
        clear_mem();
        {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'h88, 8'h05, 8'h1A, 8'hA0, 8'h20};
        run_program(50);
        chk_reg(2, 8'h00);
        chk("t2_zflag", flags[3], 1);
        chk("t2_pc", pc, 8'h21);

        // LDI R0,#7F; LDI R1,#01; ADD R0,R1; JC #40 (not taken); HLT at 7
        clear_mem();
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} = {8'h80, 8'h7F, 8'h84, 8'h01, 8'h01, 8'hC0, 8'h40};
        run_program(50);
        chk_reg(0, 8'h80);
        chk("t3_flags", flags, 4'b0101);
        chk("t3_pc", pc, 8'h08);

        // LDI R1,#55; JMP #10; HLT at 0x10, then reset out of HALT
        clear_mem();
        {mem[0], mem[1], mem[2], mem[3]} = {8'h84, 8'h55, 8'h90, 8'h10};
        run_program(50);
        chk("t4_pc", pc, 8'h11);
        chk_reg(1, 8'h55);
        reset_check();

        // Reset while ADD R0,R1 sits in EXEC
        clear_mem();
        {mem[0], mem[1], mem[2]} = {8'h84, 8'h03, 8'h01};
        @(posedge clk); #1 rst = 1'b0;
        n = 0;
        while (cyc != 5 && n < 20) begin
            @(negedge clk); n++;
            if (cyc == 2) chk("t5_ldi_retire", retire, 1);
        end
        chk("t5_exec_retire", retire, 1);
        chk("t5_alu_a", alu_a, 8'h00);
        chk("t5_alu_b", alu_b, 8'h03);
        chk("t5_alu_sel", alu_sel, 3'd0);
        #1 rst = 1'b1;
        #1 chk("t5_retire_in_rst", retire, 0);
        @(posedge clk); #1;
        chk("t5_pc", pc, RESET_PC);
        chk("t5_flags", flags, 4'h0);
        chk_reg(0, 8'h00);

        // JMP #FE; NOP at FE; LDI R3 at FF with immediate fetched from 0x00
        clear_mem();
        {mem[0], mem[1], mem[8'hFE], mem[8'hFF]} = {8'h90, 8'hFE, 8'hE0, 8'h8C};
        run_program(50);
        chk_reg(3, 8'h90);
        chk("t6_pc", pc, 8'h02);

        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            run_program(40);
        end

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
